// File: rtl/cpu_ascii_pkg.sv
// Shared ASCII constants and parser state encoding.
// Used by the decimal parser and by the byte-to-ASCII display path.
package cpu_ascii_pkg;

  localparam logic [7:0] ASC_SPACE = 8'h20;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_PLUS  = 8'h2B;
  localparam logic [7:0] ASC_MINUS = 8'h2D;
  localparam logic [7:0] ASC_ZERO  = 8'h30;
  localparam logic [7:0] ASC_NINE  = 8'h39;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SIGN  = 2'd1,
    DIGIT = 2'd2,
    FLUSH = 2'd3
  } parse_state_t;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational ASCII classifier: digit / terminator / sign, plus digit value.
// Ports: char_in (8) -> is_dig, is_trm, is_sgn, digit (4).
module ascii_char_class
  import cpu_ascii_pkg::*;
(
  input  logic [7:0] char_in,
  output logic       is_dig,
  output logic       is_trm,
  output logic       is_sgn,
  output logic [3:0] digit
);

  always_comb begin
    is_dig = (char_in >= ASC_ZERO) &&
             (char_in <= ASC_NINE);
    is_trm = (char_in == ASC_SPACE) ||
             (char_in == ASC_CR);
    is_sgn = (char_in == ASC_PLUS) ||
             (char_in == ASC_MINUS);
    // 0x30..0x39: low nibble is the digit value
    digit  = is_dig ? char_in[3:0] : 4'd0;
  end

endmodule

// File: rtl/ascii_dec_to_byte.sv
// Parses "[+|-]d{1..MAX_DIGITS}<SP|CR>" into a signed byte.
// Ports: clk, rst_n, char_in/char_valid/char_ready, value/value_valid, parse_err, busy.
module ascii_dec_to_byte
  import cpu_ascii_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int ACC_W      = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [7:0] value,
  output logic       value_valid,
  output logic       parse_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  logic       is_dig;
  logic       is_trm;
  logic       is_sgn;
  logic [3:0] digit;

  ascii_char_class u_class (
    .char_in (char_in),
    .is_dig  (is_dig),
    .is_trm  (is_trm),
    .is_sgn  (is_sgn),
    .digit   (digit)
  );

  parse_state_t     state_q, state_d;
  logic             neg_q, neg_d;
  logic [ACC_W-1:0] mag_q, mag_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       value_q, value_d;
  logic             vld_q, vld_d;
  logic             err_q, err_d;
  logic             rdy_q;

  logic             take;
  logic [ACC_W-1:0] dig_ext;
  logic [ACC_W-1:0] mag_x10;
  logic             in_range;

  assign take    = char_valid && rdy_q;
  assign dig_ext = ACC_W'(digit);
  assign mag_x10 = (mag_q << 3) + (mag_q << 1);
  // Negative side reaches one further (-128)
  assign in_range = neg_q ? (mag_q <= ACC_W'(128))
                          : (mag_q <= ACC_W'(127));

  always_comb begin
    state_d = state_q;
    neg_d   = neg_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;

    if (take) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            is_trm: ;
            is_sgn: begin
              state_d = SIGN;
              neg_d   = (char_in == ASC_MINUS);
            end
            is_dig: begin
              state_d = DIGIT;
              mag_d   = dig_ext;
              cnt_d   = CNT_W'(1);
              neg_d   = 1'b0;
            end
            default: begin
              err_d   = 1'b1;
              state_d = FLUSH;
            end
          endcase
        end
        SIGN: begin
          unique case (1'b1)
            is_dig: begin
              state_d = DIGIT;
              mag_d   = dig_ext;
              cnt_d   = CNT_W'(1);
            end
            is_trm: begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
            default: begin
              err_d   = 1'b1;
              state_d = FLUSH;
            end
          endcase
        end
        DIGIT: begin
          unique case (1'b1)
            is_dig: begin
              if (cnt_q < CNT_MAX) begin
                mag_d = mag_x10 + dig_ext;
                cnt_d = cnt_q + CNT_W'(1);
              end else begin
                err_d   = 1'b1;
                state_d = FLUSH;
              end
            end
            is_trm: begin
              state_d = IDLE;
              if (in_range) begin
                vld_d   = 1'b1;
                value_d = neg_q ? (~mag_q[7:0] + 8'd1)
                                : mag_q[7:0];
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin
              err_d   = 1'b1;
              state_d = FLUSH;
            end
          endcase
        end
        FLUSH: begin
          if (is_trm) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (state_d == IDLE) begin
        neg_d = 1'b0;
        mag_d = '0;
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      neg_q   <= 1'b0;
      mag_q   <= '0;
      cnt_q   <= '0;
      value_q <= 8'h00;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      neg_q   <= neg_d;
      mag_q   <= mag_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  assign char_ready  = rdy_q;
  assign value       = value_q;
  assign value_valid = vld_q;
  assign parse_err   = err_q;
  assign busy        = (state_q != IDLE);

endmodule
